// File: rtl/matrix_pkg.sv
// Shared constants, sweep FSM state type and one-hot helper for the LED-matrix scan driver.
package matrix_pkg;

    localparam int unsigned DEF_ROWS  = 7;
    localparam int unsigned DEF_COLS  = 5;
    localparam int unsigned DEF_DWELL = 1000;
    localparam int unsigned DEF_BLANK = 2;
    localparam int unsigned MAX_N     = 32;

    typedef enum logic [0:0] {IDLE, SWEEP} sweep_state_e;

    // Bit idx set in an MAX_N-wide vector; all-zero when idx falls outside 0..n-1.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] oh;
        oh = '0;
        if (idx < n && idx < MAX_N) begin
            oh = MAX_N'(1) << idx;
        end
        return oh;
    endfunction

endpackage

// File: rtl/matrix_row_scanner.sv
// Free-running row/dwell counters with blanking decode; drives row_sel, col_out and frame_tick.
module matrix_row_scanner
    import matrix_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned DWELL = DEF_DWELL,
    parameter int unsigned BLANK = DEF_BLANK,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COLS-1:0]  row_pixels,
    output logic [ROW_W-1:0] row_idx,
    output logic             frame_end,
    output logic [ROWS-1:0]  row_sel,
    output logic [COLS-1:0]  col_out,
    output logic             frame_tick
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [DW_W-1:0]  dwell_cnt;
    logic             last_dwell;
    logic             last_row;
    logic             blanked;
    logic [MAX_N-1:0] oh;

    assign last_dwell = (dwell_cnt == DW_W'(DWELL - 1));
    assign last_row   = (row_idx == ROW_W'(ROWS - 1));
    assign blanked    = (dwell_cnt < DW_W'(BLANK));
    assign frame_end  = last_row && last_dwell;
    assign oh         = onehot(32'(row_idx), ROWS);

    // Outputs lag the counters by one register stage; row_pixels is already muxed by row_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt  <= '0;
            row_idx    <= '0;
            row_sel    <= '0;
            col_out    <= '0;
            frame_tick <= 1'b0;
        end else begin
            dwell_cnt <= last_dwell ? '0 : dwell_cnt + DW_W'(1);
            if (last_dwell) begin
                row_idx <= last_row ? '0 : row_idx + ROW_W'(1);
            end
            row_sel    <= blanked ? '0 : oh[ROWS-1:0];
            col_out    <= blanked ? '0 : row_pixels;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// LED-matrix driver: framebuffer, write handshake, clear sweep FSM and sticky out-of-range flag.
// Define MATRIX_DOUBLE_BUFFER_EN to display a front buffer refreshed from the back buffer per frame.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned DWELL = DEF_DWELL,
    parameter int unsigned BLANK = DEF_BLANK,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COL_W-1:0] wr_col,
    input  logic             wr_data,
    input  logic             clr,
    output logic [ROWS-1:0]  row_sel,
    output logic [COLS-1:0]  col_out,
    output logic             frame_tick,
    output logic             err_oob
);

    sweep_state_e    state_q;
    logic [ROW_W-1:0] sweep_row_q;
    logic [COLS-1:0]  fb_q [ROWS];
    logic [COLS-1:0]  row_pixels;
    logic [ROW_W-1:0] row_idx;
    logic             frame_end;
    logic             wr_fire;
    logic             in_range;

    assign wr_fire  = wr_valid && wr_ready;
    assign in_range = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);

    // Sweep FSM; clr always (re)starts from row 0 and wins over a same-cycle out-of-range write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sweep_row_q <= '0;
            wr_ready    <= 1'b1;
            err_oob     <= 1'b0;
        end else if (clr) begin
            state_q     <= SWEEP;
            sweep_row_q <= '0;
            wr_ready    <= 1'b0;
            err_oob     <= 1'b0;
        end else begin
            if (wr_fire && !in_range) begin
                err_oob <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    wr_ready <= 1'b1;
                end
                SWEEP: begin
                    if (sweep_row_q == ROW_W'(ROWS - 1)) begin
                        state_q  <= IDLE;
                        wr_ready <= 1'b1;
                    end else begin
                        sweep_row_q <= sweep_row_q + ROW_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

    // Writes only land in IDLE (wr_ready low in SWEEP), so they never collide with a row clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                fb_q[r] <= '0;
            end
        end else begin
            if (wr_fire && in_range) begin
                fb_q[wr_row][wr_col] <= wr_data;
            end
            if (state_q == SWEEP) begin
                fb_q[sweep_row_q] <= '0;
            end
        end
    end

`ifdef MATRIX_DOUBLE_BUFFER_EN
    logic [COLS-1:0] front_q [ROWS];

    // Copy takes the back buffer as it stood before this edge's write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                front_q[r] <= '0;
            end
        end else if (frame_end) begin
            front_q <= fb_q;
        end
    end

    assign row_pixels = front_q[row_idx];
`else
    logic unused_frame_end;
    assign unused_frame_end = frame_end;
    assign row_pixels       = fb_q[row_idx];
`endif

    matrix_row_scanner #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) u_scanner (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_pixels (row_pixels),
        .row_idx    (row_idx),
        .frame_end  (frame_end),
        .row_sel    (row_sel),
        .col_out    (col_out),
        .frame_tick (frame_tick)
    );

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver (ROWS=7, COLS=5, DWELL=8, BLANK=2); cycle k is sampled
// on the falling edge just before the k-th rising edge after reset release.
module tb_matrix_scan_driver;

    localparam int unsigned ROWS  = 7;
    localparam int unsigned COLS  = 5;
    localparam int unsigned DWELL = 8;
    localparam int unsigned BLANK = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_data  = 1'b0;
    logic       clr      = 1'b0;
    logic [2:0] wr_row   = '0;
    logic [2:0] wr_col   = '0;
    logic       wr_ready;
    logic [6:0] row_sel;
    logic [4:0] col_out;
    logic       frame_tick;
    logic       err_oob;

    int cyc;
    int errors = 0;
    int checks = 0;

    matrix_scan_driver #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .clr        (clr),
        .row_sel    (row_sel),
        .col_out    (col_out),
        .frame_tick (frame_tick),
        .err_oob    (err_oob)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic wait_cycle(input int k);
        if (cyc > k) begin
            checks++;
            errors++;
            $display("FAIL wait_cycle: already at cycle %0d, required %0d", cyc, k);
        end
        while (cyc < k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        clr      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_at(input int k, input int r, input int c, input logic d);
        wait_cycle(k);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ready@%0d: wr_ready=%b required 1", k, wr_ready);
        end
        wr_valid = 1'b1;
        wr_row   = 3'(r);
        wr_col   = 3'(c);
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_clr(input int k);
        wait_cycle(k);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({row_sel, col_out, frame_tick, wr_ready, err_oob} !== {7'd0, 5'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: sel=%b col=%b tick=%b rdy=%b oob=%b required 0/0/0/1/0",
                     row_sel, col_out, frame_tick, wr_ready, err_oob);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({row_sel, col_out, frame_tick, wr_ready, err_oob} !== {7'd0, 5'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL cycle0_values: sel=%b col=%b tick=%b rdy=%b oob=%b required 0/0/0/1/0",
                     row_sel, col_out, frame_tick, wr_ready, err_oob);
        end
    endtask

    task automatic test_scan();
        int ticks;
        logic [6:0] es;
        logic et;
        ticks = 0;
        do_reset();
        for (int k = 0; k <= 120; k++) begin
            wait_cycle(k);
            if (k == 0) begin
                es = '0;
                et = 1'b0;
            end else begin
                es = (((k - 1) % 8) < 2) ? 7'd0 : 7'(1 << (((k - 1) / 8) % 7));
                et = (((k - 1) % 56) == 55);
            end
            if (frame_tick === 1'b1) ticks++;
            checks++;
            if ({row_sel, frame_tick, col_out} !== {es, et, 5'd0}) begin
                errors++;
                $display("FAIL scan@%0d: sel=%b tick=%b col=%b required %b %b 00000",
                         k, row_sel, frame_tick, col_out, es, et);
            end
        end
        checks++;
        if (ticks != 2) begin
            errors++;
            $display("FAIL tick_count: saw %0d frame_ticks in cycles 0..120, required 2", ticks);
        end
    endtask

    task automatic test_write();
        int dw;
        int rw;
        logic vis;
        logic [4:0] ec;
        do_reset();
        write_at(5, 3, 4, 1'b1);
        for (int k = 9; k <= 100; k++) begin
            wait_cycle(k);
            dw = (k - 1) % 8;
            rw = ((k - 1) / 8) % 7;
`ifdef MATRIX_DOUBLE_BUFFER_EN
            vis = (k >= 57);
`else
            vis = (k >= 7);
`endif
            ec = (vis && rw == 3 && dw >= 2) ? 5'b10000 : 5'b00000;
            checks++;
            if (col_out !== ec) begin
                errors++;
                $display("FAIL write_pixel@%0d: col_out=%b required %b", k, col_out, ec);
            end
        end
    endtask

    task automatic test_oob();
        do_reset();
        wait_cycle(4);
        checks++;
        if (err_oob !== 1'b0) begin
            errors++;
            $display("FAIL oob_before: err_oob=%b required 0", err_oob);
        end
        write_at(4, 7, 0, 1'b1);
        for (int k = 5; k <= 56; k++) begin
            wait_cycle(k);
            checks++;
            if (col_out !== 5'd0 || err_oob !== 1'b1) begin
                errors++;
                $display("FAIL oob_row@%0d: col_out=%b err_oob=%b required 00000 1", k, col_out, err_oob);
            end
        end
        wait_cycle(60);
        checks++;
        if (err_oob !== 1'b1) begin
            errors++;
            $display("FAIL oob_sticky: err_oob=%b required 1", err_oob);
        end
        pulse_clr(60);
        checks++;
        if (err_oob !== 1'b0) begin
            errors++;
            $display("FAIL oob_clr: err_oob=%b required 0", err_oob);
        end
        write_at(70, 0, 5, 1'b1);
        checks++;
        if (err_oob !== 1'b1) begin
            errors++;
            $display("FAIL oob_col: err_oob=%b required 1", err_oob);
        end
        wait_cycle(117);
        checks++;
        if (col_out !== 5'd0) begin
            errors++;
            $display("FAIL oob_col_fb: col_out=%b required 00000", col_out);
        end
    endtask

    task automatic test_back_to_back_and_sweep();
        logic exp_rdy;
        logic [4:0] ec;
        do_reset();
        wait_cycle(1);
        for (int i = 0; i < 35; i++) begin
            wr_valid = 1'b1;
            wr_row   = 3'(i / 5);
            wr_col   = 3'(i % 5);
            wr_data  = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wait_cycle(60);
        checks++;
        if (col_out !== 5'b11111) begin
            errors++;
            $display("FAIL fill_row0: col_out=%b required 11111", col_out);
        end
        wait_cycle(70);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL sweep_pre: wr_ready=%b required 1", wr_ready);
        end
        pulse_clr(70);
        for (int k = 71; k <= 78; k++) begin
            wait_cycle(k);
            exp_rdy = (k == 78);
            checks++;
            if (wr_ready !== exp_rdy) begin
                errors++;
                $display("FAIL sweep_ready@%0d: wr_ready=%b required %b", k, wr_ready, exp_rdy);
            end
        end
        wait_cycle(100);
`ifdef MATRIX_DOUBLE_BUFFER_EN
        ec = 5'b11111;
`else
        ec = 5'b00000;
`endif
        checks++;
        if (col_out !== ec) begin
            errors++;
            $display("FAIL sweep_row5@100: col_out=%b required %b", col_out, ec);
        end
        for (int k = 113; k <= 168; k++) begin
            wait_cycle(k);
            checks++;
            if (col_out !== 5'd0) begin
                errors++;
                $display("FAIL sweep_blank@%0d: col_out=%b required 00000", k, col_out);
            end
        end
        pulse_clr(170);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reclr_171: wr_ready=%b required 0", wr_ready);
        end
        pulse_clr(173);
        for (int k = 176; k <= 181; k++) begin
            wait_cycle(k);
            exp_rdy = (k == 181);
            checks++;
            if (wr_ready !== exp_rdy) begin
                errors++;
                $display("FAIL reclr_ready@%0d: wr_ready=%b required %b", k, wr_ready, exp_rdy);
            end
        end
    endtask

    task automatic test_double_buffer();
        logic [4:0] e30;
        logic [4:0] e93;
`ifdef MATRIX_DOUBLE_BUFFER_EN
        e30 = 5'b00000;
        e93 = 5'b00000;
`else
        e30 = 5'b00001;
        e93 = 5'b00010;
`endif
        do_reset();
        write_at(20, 3, 0, 1'b1);
        wait_cycle(30);
        checks++;
        if (col_out !== e30) begin
            errors++;
            $display("FAIL dbuf_30: col_out=%b required %b", col_out, e30);
        end
        write_at(55, 4, 1, 1'b1);
        wait_cycle(85);
        checks++;
        if (col_out !== 5'b00001) begin
            errors++;
            $display("FAIL dbuf_85: col_out=%b required 00001", col_out);
        end
        wait_cycle(93);
        checks++;
        if (col_out !== e93) begin
            errors++;
            $display("FAIL dbuf_93: col_out=%b required %b", col_out, e93);
        end
        wait_cycle(149);
        checks++;
        if (col_out !== 5'b00010) begin
            errors++;
            $display("FAIL dbuf_149: col_out=%b required 00010", col_out);
        end
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        write_at(2, 1, 2, 1'b1);
        pulse_clr(10);
        wait_cycle(12);
        checks++;
        if ({wr_ready, row_sel, col_out} !== {1'b0, 7'b0000010, 5'b00100}) begin
            errors++;
            $display("FAIL pre_abort: rdy=%b sel=%b col=%b required 0 0000010 00100",
                     wr_ready, row_sel, col_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({row_sel, col_out, frame_tick, wr_ready, err_oob} !== {7'd0, 5'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_abort: sel=%b col=%b tick=%b rdy=%b oob=%b required 0/0/0/1/0",
                     row_sel, col_out, frame_tick, wr_ready, err_oob);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: wr_ready=%b required 1", wr_ready);
        end
        wait_cycle(12);
        checks++;
        if ({row_sel, col_out} !== {7'b0000010, 5'b00000}) begin
            errors++;
            $display("FAIL abort_fb: sel=%b col=%b required 0000010 00000", row_sel, col_out);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write();
        test_oob();
        test_back_to_back_and_sweep();
        test_double_buffer();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_scan_driver.md
# matrix_scan_driver

Parametrised, time-multiplexed LED-matrix driver and successor to the combinational coordinate decoder. The block holds a ROWS×COLS pixel framebuffer and accepts pixel set/clear writes by (row, column) coordinate over a valid/ready handshake. It continuously scans the matrix one row at a time, with a programmable dwell and anti-ghosting blanking. It sits between the game/control logic and the matrix row/column pins.

## Interface
- ROWS, 7, matrix row count (≥2)
- COLS, 5, matrix column count (≥1)
- DWELL, 1000, clock cycles per row slot (≥2)
- BLANK, 2, blanked cycles at the start of each row slot (0 ≤ BLANK < DWELL)
- Derived localparams: ROW_W = $clog2(ROWS), COL_W = $clog2(COLS), DW_W = $clog2(DWELL)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write can be accepted
- wr_row  in  ROW_W  target row
- wr_col  in  COL_W  target column
- wr_data  in  1  1 sets the pixel, 0 clears it
- clr  in  1  one-cycle pulse that starts a clear-all sweep
- row_sel  out  ROWS  one-hot active row; all-zero while blanked
- col_out  out  COLS  pixel data for the active row
- frame_tick  out  1  one-cycle pulse after the last row slot of each frame
- err_oob  out  1  sticky flag: an out-of-range coordinate was written

## Operation
- Framebuffer: ROWS×COLS bits.
- Write handshake: a write is accepted on a cycle with wr_valid && wr_ready. The fb bit [wr_row][wr_col] takes wr_data at the end of that cycle.
- Out-of-range write (wr_row ≥ ROWS or wr_col ≥ COLS): the write is accepted, the framebuffer is untouched, and err_oob is set.
- Scan counters:
  - dwell_cnt counts 0..DWELL-1.
  - row_idx counts 0..ROWS-1 and advances when dwell_cnt wraps. It wraps from ROWS-1 back to 0.
- Registered outputs, loaded every cycle from the current counters:
  - row_sel = 0 if dwell_cnt < BLANK, else onehot(row_idx).
  - col_out = 0 if dwell_cnt < BLANK, else displayed row[row_idx].
  - frame_tick = (row_idx == ROWS-1 && dwell_cnt == DWELL-1).
- Clear sweep: a clr pulse enters the SWEEP state. SWEEP clears one row per cycle, rows 0..ROWS-1, and lasts ROWS cycles. FSM states are IDLE and SWEEP.
  - wr_ready = 0 in SWEEP. wr_ready is registered and equals 1 in IDLE.
  - err_oob is cleared on the cycle after clr is sampled.
  - clr during SWEEP restarts the sweep from row 0.
  - A write accepted in the same cycle clr is sampled still completes, then is erased by the sweep.
- Scanning never stops. Clear and write activity does not perturb the scan counters.

## Timing
- Reset values: row_sel=0, col_out=0, frame_tick=0, wr_ready=1, err_oob=0, framebuffer all 0, dwell_cnt=0, row_idx=0, FSM=IDLE.
- Reset asserted mid-sweep or mid-frame aborts immediately to the reset values.
- Cycle 0 is the first clock edge after rst_n deasserts.
  - Row r is driven on cycles r·DWELL+BLANK+1 through (r+1)·DWELL.
  - The first frame_tick occurs in cycle ROWS·DWELL, then every ROWS·DWELL cycles.
- Write latency (single-buffer): a write accepted in cycle t is visible on col_out from cycle t+2, provided that row is driven then.
- Sweep: clr sampled in cycle t gives wr_ready=0 in cycles t+1..t+ROWS and 1 again in cycle t+ROWS+1.

## Configuration
- Macro: MATRIX_DOUBLE_BUFFER_EN.
- Defined:
  - Writes and sweeps target a back buffer.
  - The front buffer is displayed.
  - front ← back on the same edge that registers frame_tick.
  - A write accepted in that boundary cycle is not in the copy and appears one frame later.
- Undefined: a single buffer; writes are visible per the single-buffer latency above.

## Structure
- Package matrix_pkg holds:
  - default ROWS/COLS/DWELL/BLANK constants
  - the FSM state typedef (IDLE, SWEEP)
  - an onehot(idx, n) function
- One sub-module, matrix_row_scanner, holds dwell_cnt/row_idx, blanking decode, row_sel and frame_tick.
- The top level holds the framebuffer(s), handshake, sweep FSM and err_oob.

## Test plan
- Parameters for the bench: ROWS=7, COLS=5, DWELL=8, BLANK=2.
- Scan after reset: no writes → row_sel=0 in cycles 0..2; row_sel=7'b0000001 in cycles 3..8; 7'b0000010 from cycle 11; frame_tick only in cycles 56, 112.
- Write (row 3, col 4, 1) accepted at cycle 5 → col_out=5'b10000 while row_sel=7'b0001000 (cycles 27..32); other rows show 0.
- Out-of-range write (row 7, col 0) → framebuffer unchanged; err_oob=1 from the next cycle; a later clr drops err_oob.
- After filling all pixels, clr at cycle t → wr_ready=0 for exactly 7 cycles; all col_out=0 in the next frame; a second clr at t+3 extends wr_ready=0 until t+10.
- Double-buffer build: a write accepted at cycle 20 stays invisible until the frame_tick at cycle 56, then is displayed. A write on the boundary cycle 55 appears only after cycle 112.
- Reset asserted mid-sweep at cycle t+2 → all outputs return to reset values asynchronously; wr_ready=1 once rst_n is high.
